// File: rtl/interface_debug_pkg.sv
// interface_debug: CCI-P line types, mdata tags and the control-poll FSM state encoding.
package interface_debug;
    typedef logic [41:0]  t_cci_clAddr;
    typedef logic [511:0] t_cci_clData;

    localparam logic [15:0] READ_CTRL_MDATA = 16'd3;
    localparam logic [15:0] READ_RUN_MDATA  = 16'd5;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        WAIT_ACK,
        GAP,
        DRAIN,
        HOLD
    } e_poll_state;
endpackage

// File: rtl/sat_down_counter.sv
// sat_down_counter: loadable down counter that stops at zero and flags it.
module sat_down_counter #(
    parameter int unsigned    W    = 8,
    parameter logic [W-1:0]   LOAD = '0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? LOAD : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/ctrl_poll_engine.sv
// ctrl_poll_engine: polls the host control word over CCI-P c0 with one read outstanding,
// re-polling after stale words and re-issuing after response timeouts.
import interface_debug::*;

module ctrl_poll_engine #(
    parameter int unsigned POLL_GAP    = 64,
    parameter int unsigned RSP_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  t_cci_clAddr ctrl_addr,
    input  logic        c0_alm_full,
    output logic        c0_req_valid,
    output t_cci_clAddr c0_req_addr,
    output logic [15:0] c0_req_mdata,
    input  logic        c0_rsp_valid,
    input  logic [15:0] c0_rsp_mdata,
    input  t_cci_clData c0_rsp_data,
    input  logic        ctrl_ack,
    input  logic        ctrl_valid,
    output logic        ctrl_resp_valid,
    output t_cci_clData rd_resp_data,
    output logic [31:0] poll_count
);
    localparam int unsigned     GW    = $clog2(POLL_GAP + 1);
    localparam int unsigned     TW    = $clog2(RSP_TIMEOUT + 1);
    localparam logic [GW-1:0]   GLOAD = GW'(POLL_GAP - 1);
    localparam logic [TW-1:0]   TLOAD = TW'(RSP_TIMEOUT - 1);

    e_poll_state state_q, state_d;
    logic        req_valid_q, req_valid_d;
    t_cci_clAddr req_addr_q, req_addr_d;
    logic        resp_valid_q, resp_valid_d;
    t_cci_clData resp_data_q, resp_data_d;
    logic [31:0] poll_count_q, poll_count_d;
    logic        match, issue, gap_load, gap_zero, to_load, to_zero;

    assign match = c0_rsp_valid && (c0_rsp_mdata == READ_CTRL_MDATA);
    assign issue = (state_q == REQ) && enable && !c0_alm_full;

    always_comb begin
        state_d  = state_q;
        gap_load = 1'b0;
        to_load  = issue;
        case (state_q)
            IDLE:     if (enable) state_d = REQ;
            REQ:      if (!enable) state_d = IDLE;
                      else if (!c0_alm_full) state_d = WAIT_RSP;
            WAIT_RSP: if (match) state_d = WAIT_ACK;
                      else if (!enable || to_zero) begin
                          state_d = DRAIN;
                          to_load = 1'b1;
                      end
            WAIT_ACK: if (ctrl_ack) begin
                          if (!enable) state_d = IDLE;
                          else if (ctrl_valid) state_d = HOLD;
                          else begin
                              state_d  = GAP;
                              gap_load = 1'b1;
                          end
                      end
            GAP:      if (!enable) state_d = IDLE;
                      else if (gap_zero) state_d = REQ;
            HOLD:     if (!enable) state_d = IDLE;
            // A late match is swallowed here; the timeout reload bounds the wait.
            DRAIN:    if (match || to_zero) state_d = enable ? REQ : IDLE;
            default:  state_d = IDLE;
        endcase
        req_valid_d  = issue;
        req_addr_d   = issue ? ctrl_addr : req_addr_q;
        resp_valid_d = (state_q == WAIT_RSP) && match;
        resp_data_d  = resp_valid_d ? c0_rsp_data : resp_data_q;
        poll_count_d = (issue && poll_count_q != 32'hFFFF_FFFF) ? poll_count_q + 32'd1 : poll_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            poll_count_q <= '0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            poll_count_q <= poll_count_d;
        end
    end

    sat_down_counter #(.W(GW), .LOAD(GLOAD)) u_gap (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (gap_load),
        .dec     (state_q == GAP),
        .zero    (gap_zero)
    );

    sat_down_counter #(.W(TW), .LOAD(TLOAD)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (to_load),
        .dec     ((state_q == WAIT_RSP) || (state_q == DRAIN)),
        .zero    (to_zero)
    );

    assign c0_req_valid    = req_valid_q;
    assign c0_req_addr     = req_addr_q;
    assign c0_req_mdata    = READ_CTRL_MDATA;
    assign ctrl_resp_valid = resp_valid_q;
    assign rd_resp_data    = resp_data_q;
    assign poll_count      = poll_count_q;
endmodule

// File: tb/tb_ctrl_poll_engine.sv
// tb_ctrl_poll_engine: cycle-by-cycle vector table through poll, stale repoll, back-pressure,
// timeout/drain and enable drop, then async reset in WAIT_ACK and restart.
module tb_ctrl_poll_engine;
    typedef struct {
        logic        en, af, rv;
        logic [15:0] md;
        logic [31:0] rd;
        logic        ack, vld;
        logic        e_req, e_rsp;
        logic [31:0] e_pc, e_data;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic [41:0]  ctrl_addr = 42'h1000;
    logic         c0_alm_full = 1'b0;
    logic         c0_req_valid;
    logic [41:0]  c0_req_addr;
    logic [15:0]  c0_req_mdata;
    logic         c0_rsp_valid = 1'b0;
    logic [15:0]  c0_rsp_mdata = '0;
    logic [511:0] c0_rsp_data = '0;
    logic         ctrl_ack = 1'b0;
    logic         ctrl_valid = 1'b0;
    logic         ctrl_resp_valid;
    logic [511:0] rd_resp_data;
    logic [31:0]  poll_count;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[$];

    localparam logic [31:0] D1 = 32'hA5A5_0001, D2 = 32'h5A5A_0002, DX = 32'hDEAD_0005,
                            DL = 32'hDEAD_0003, DE = 32'hDEAD_0007, D4 = 32'h1234_5678;

    always #5 clk = ~clk;

    ctrl_poll_engine #(.POLL_GAP(8), .RSP_TIMEOUT(16)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .ctrl_addr       (ctrl_addr),
        .c0_alm_full     (c0_alm_full),
        .c0_req_valid    (c0_req_valid),
        .c0_req_addr     (c0_req_addr),
        .c0_req_mdata    (c0_req_mdata),
        .c0_rsp_valid    (c0_rsp_valid),
        .c0_rsp_mdata    (c0_rsp_mdata),
        .c0_rsp_data     (c0_rsp_data),
        .ctrl_ack        (ctrl_ack),
        .ctrl_valid      (ctrl_valid),
        .ctrl_resp_valid (ctrl_resp_valid),
        .rd_resp_data    (rd_resp_data),
        .poll_count      (poll_count)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic en, af, rv, input logic [15:0] md, input logic [31:0] rd,
                               input logic ack, vld, e_req, e_rsp, input logic [31:0] e_pc, e_data);
        vec_t r;
        r.en = en; r.af = af; r.rv = rv; r.md = md; r.rd = rd; r.ack = ack; r.vld = vld;
        r.e_req = e_req; r.e_rsp = e_rsp; r.e_pc = e_pc; r.e_data = e_data;
        return r;
    endfunction

    initial begin
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(v(1,0,1,5,DX,0,0, 1,0,1,0));
        tbl.push_back(v(1,0,1,3,D1,0,0, 0,0,1,0));
        tbl.push_back(v(1,0,0,0,0,0,0, 0,1,1,D1));
        tbl.push_back(v(1,0,0,0,0,1,0, 0,0,1,D1));
        for (int i = 6; i <= 14; i++) tbl.push_back(v(1,0,0,0,0,0,0, 0,0,1,D1));
        tbl.push_back(v(1,0,1,3,D2,0,0, 1,0,2,D1));
        tbl.push_back(v(1,0,0,0,0,0,0, 0,1,2,D2));
        tbl.push_back(v(1,0,0,0,0,1,1, 0,0,2,D2));
        for (int i = 18; i <= 22; i++) tbl.push_back(v(1,0,0,0,0,0,0, 0,0,2,D2));
        for (int i = 23; i <= 24; i++) tbl.push_back(v(0,0,0,0,0,0,0, 0,0,2,D2));
        for (int i = 25; i <= 45; i++) tbl.push_back(v(1,1,0,0,0,0,0, 0,0,2,D2));
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,2,D2));
        for (int i = 47; i <= 64; i++) tbl.push_back(v(1,0,0,0,0,0,0, i == 47,0,3,D2));
        tbl.push_back(v(1,0,1,3,DL,0,0, 0,0,3,D2));
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,3,D2));
        tbl.push_back(v(1,0,0,0,0,0,0, 1,0,4,D2));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,4,D2));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,4,D2));
        tbl.push_back(v(0,0,1,3,DE,0,0, 0,0,4,D2));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,4,D2));
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,4,D2));
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,4,D2));
        tbl.push_back(v(0,0,1,3,D4,0,0, 1,0,5,D2));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,1,5,D4));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_valid", {511'd0, c0_req_valid}, 512'd0);
        chk("reset resp_valid", {511'd0, ctrl_resp_valid}, 512'd0);
        chk("reset poll_count", {480'd0, poll_count}, 512'd0);
        chk("reset rd_resp_data", rd_resp_data, 512'd0);
        chk("reset req_addr", {470'd0, c0_req_addr}, 512'd0);
        chk("req_mdata", {496'd0, c0_req_mdata}, 512'd3);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            enable = tbl[i].en;
            c0_alm_full = tbl[i].af;
            c0_rsp_valid = tbl[i].rv;
            c0_rsp_mdata = tbl[i].md;
            c0_rsp_data = {16{tbl[i].rd}};
            ctrl_ack = tbl[i].ack;
            ctrl_valid = tbl[i].vld;
            @(negedge clk);
            chk($sformatf("row%0d req_valid", i), {511'd0, c0_req_valid}, {511'd0, tbl[i].e_req});
            chk($sformatf("row%0d resp_valid", i), {511'd0, ctrl_resp_valid}, {511'd0, tbl[i].e_rsp});
            chk($sformatf("row%0d poll_count", i), {480'd0, poll_count}, {480'd0, tbl[i].e_pc});
            chk($sformatf("row%0d rd_resp_data", i), rd_resp_data, {16{tbl[i].e_data}});
        end
        chk("req_addr before reset", {470'd0, c0_req_addr}, 512'h1000);

        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async req_valid", {511'd0, c0_req_valid}, 512'd0);
        chk("async resp_valid", {511'd0, ctrl_resp_valid}, 512'd0);
        chk("async poll_count", {480'd0, poll_count}, 512'd0);
        chk("async rd_resp_data", rd_resp_data, 512'd0);
        chk("async req_addr", {470'd0, c0_req_addr}, 512'd0);

        @(negedge clk);
        reset_n = 1'b1;
        enable = 1'b1;
        ctrl_addr = 42'h2000;
        c0_rsp_valid = 1'b0;
        ctrl_ack = 1'b0;
        begin
            int n;
            n = 0;
            while (n < 10 && !c0_req_valid) begin
                @(negedge clk);
                n++;
            end
            chk("restart latency", 512'(n), 512'd2);
        end
        chk("restart req_valid", {511'd0, c0_req_valid}, 512'd1);
        chk("restart poll_count", {480'd0, poll_count}, 512'd1);
        chk("restart req_addr", {470'd0, c0_req_addr}, 512'h2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
